// File: rtl/hazard_ctrl_if.sv
// D-stage hazard query bundle: operand/destination descriptors in, pipeline
// control, forwarding selects and stall statistics out.
interface hazard_ctrl_if #(
  parameter int unsigned AW    = 5,
  parameter int unsigned TW    = 3,
  parameter int unsigned CNT_W = 32
);
  logic [AW-1:0]    rs_d;
  logic [AW-1:0]    rt_d;
  logic             rs_used;
  logic             rt_used;
  logic [TW-1:0]    rs_tuse;
  logic [TW-1:0]    rt_tuse;
  logic [AW-1:0]    a3_d;
  logic [TW-1:0]    tnew_d;
  logic             md_start_d;
  logic             md_div_d;
  logic             md_use_d;
  logic             ifu_en;
  logic             d_reg_en;
  logic             e_reg_clr;
  logic [1:0]       fwd_rs_sel;
  logic [1:0]       fwd_rt_sel;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output rs_d, rt_d, rs_used, rt_used, rs_tuse, rt_tuse, a3_d, tnew_d,
           md_start_d, md_div_d, md_use_d,
    input  ifu_en, d_reg_en, e_reg_clr, fwd_rs_sel, fwd_rt_sel, md_busy, stall_cnt
  );

  modport slave (
    input  rs_d, rt_d, rs_used, rt_used, rs_tuse, rt_tuse, a3_d, tnew_d,
           md_start_d, md_div_d, md_use_d,
    output ifu_en, d_reg_en, e_reg_clr, fwd_rs_sel, fwd_rt_sel, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Tuse/Tnew hazard controller: E/M/W result scoreboard, stall and forwarding
// decisions for the D stage, multiply/divide busy tracking, stall counter.
module hazard_ctrl #(
  parameter int unsigned AW       = 5,
  parameter int unsigned TW       = 3,
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10,
  parameter int unsigned CNT_W    = 32
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  bus
);

  localparam int unsigned MD_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int unsigned MDW    = (MD_MAX < 1) ? 1 : $clog2(MD_MAX + 1);

  typedef struct packed {
    logic [AW-1:0] a3;
    logic [TW-1:0] tnew;
  } sb_t;

  sb_t              e_q, m_q, w_q;
  sb_t              e_d, m_d, w_d;
  logic [MDW-1:0]   md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             rs_stall, rt_stall, md_stall, stall;
  logic [1:0]       rs_sel, rt_sel;

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // Returns {stall, fwd_sel}; only the youngest matching stage is considered.
  function automatic logic [2:0] op_chk(input logic [AW-1:0] addr, input logic used,
                                        input logic [TW-1:0] tuse,
                                        input sb_t e, input sb_t m, input sb_t w);
    logic          hit;
    logic [TW-1:0] tn;
    logic [1:0]    code;
    hit  = 1'b0;
    tn   = '0;
    code = 2'd0;
    if (addr != '0 && used) begin
      if (e.a3 == addr) begin
        hit = 1'b1; tn = e.tnew; code = 2'd1;
      end else if (m.a3 == addr) begin
        hit = 1'b1; tn = m.tnew; code = 2'd2;
      end else if (w.a3 == addr) begin
        hit = 1'b1; tn = w.tnew; code = 2'd3;
      end
    end
    return {hit && (tn > tuse), (hit && tn == '0) ? code : 2'd0};
  endfunction

  always_comb begin
    {rs_stall, rs_sel} = op_chk(bus.rs_d, bus.rs_used, bus.rs_tuse, e_q, m_q, w_q);
    {rt_stall, rt_sel} = op_chk(bus.rt_d, bus.rt_used, bus.rt_tuse, e_q, m_q, w_q);
    md_stall = bus.md_use_d && (md_cnt_q != '0);
    stall    = rs_stall || rt_stall || md_stall;

    w_d = '{a3: m_q.a3, tnew: sat_dec(m_q.tnew)};
    m_d = '{a3: e_q.a3, tnew: sat_dec(e_q.tnew)};
    e_d = stall ? sb_t'('0) : '{a3: bus.a3_d, tnew: bus.tnew_d};

    // A start only loads when it actually leaves D.
    md_cnt_d = md_cnt_q;
    if (bus.md_start_d && !stall)
      md_cnt_d = bus.md_div_d ? MDW'(DIV_CYC) : MDW'(MULT_CYC);
    else if (md_cnt_q != '0)
      md_cnt_d = md_cnt_q - MDW'(1);

    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q         <= '0;
      m_q         <= '0;
      w_q         <= '0;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      m_q         <= m_d;
      w_q         <= w_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    bus.ifu_en     = ~stall;
    bus.d_reg_en   = ~stall;
    bus.e_reg_clr  = stall;
    bus.fwd_rs_sel = rs_sel;
    bus.fwd_rt_sel = rt_sel;
    bus.md_busy    = (md_cnt_q != '0);
    bus.stall_cnt  = stall_cnt_q;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, forwarding priority, MDU busy,
// reset abort and stall-counter saturation on a narrow-counter instance.
module tb_hazard_ctrl;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;
  int   n;

  hazard_ctrl_if #(.AW(5), .TW(3), .CNT_W(32)) bus ();
  hazard_ctrl_if #(.AW(5), .TW(3), .CNT_W(4))  bus2 ();

  hazard_ctrl #(.AW(5), .TW(3), .MULT_CYC(5), .DIV_CYC(10), .CNT_W(32)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  hazard_ctrl #(.AW(5), .TW(3), .MULT_CYC(5), .DIV_CYC(20), .CNT_W(4)) u_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic idle();
    bus.rs_d = '0; bus.rt_d = '0; bus.rs_used = 1'b0; bus.rt_used = 1'b0;
    bus.rs_tuse = '0; bus.rt_tuse = '0; bus.a3_d = '0; bus.tnew_d = '0;
    bus.md_start_d = 1'b0; bus.md_div_d = 1'b0; bus.md_use_d = 1'b0;
  endtask

  task automatic idle2();
    bus2.rs_d = '0; bus2.rt_d = '0; bus2.rs_used = 1'b0; bus2.rt_used = 1'b0;
    bus2.rs_tuse = '0; bus2.rt_tuse = '0; bus2.a3_d = '0; bus2.tnew_d = '0;
    bus2.md_start_d = 1'b0; bus2.md_div_d = 1'b0; bus2.md_use_d = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts stalled cycles with the current D contents, bounded at 40.
  task automatic count_stall(output int cnt);
    cnt = 0;
    #1;
    while (bus.ifu_en === 1'b0 && cnt < 40) begin
      cnt++;
      tick();
      #1;
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    idle(); idle2();
    reset = 1'b0;
    tick(); tick();
    chk("rst_ifu_en", 32'(bus.ifu_en), 32'd1);
    chk("rst_d_reg_en", 32'(bus.d_reg_en), 32'd1);
    chk("rst_e_reg_clr", 32'(bus.e_reg_clr), 32'd0);
    chk("rst_fwd_rs", 32'(bus.fwd_rs_sel), 32'd0);
    chk("rst_fwd_rt", 32'(bus.fwd_rt_sel), 32'd0);
    chk("rst_md_busy", 32'(bus.md_busy), 32'd0);
    chk("rst_stall_cnt", bus.stall_cnt, 32'd0);
    reset = 1'b1;
    tick();

    // lw $8 then beq $8 with tuse 0: two stall cycles, then forward from W.
    bus.a3_d = 5'd8; bus.tnew_d = 3'd2;
    #1 chk("lw_no_stall", 32'(bus.ifu_en), 32'd1);
    tick();
    idle(); bus.rs_d = 5'd8; bus.rs_used = 1'b1; bus.rs_tuse = 3'd0;
    #1 chk("ld_use_stall_e", 32'(bus.e_reg_clr), 32'd1);
    chk("ld_use_d_en", 32'(bus.d_reg_en), 32'd0);
    tick();
    chk("ld_use_stall_m", 32'(bus.ifu_en), 32'd0);
    tick();
    chk("ld_use_release", 32'(bus.ifu_en), 32'd1);
    chk("ld_use_fwd_w", 32'(bus.fwd_rs_sel), 32'd3);
    chk("ld_use_cnt", bus.stall_cnt, 32'd2);
    tick();

    // addu $9 (tnew 1) then rt = 9 with tuse 1: no stall, forward from M next cycle.
    idle(); bus.a3_d = 5'd9; bus.tnew_d = 3'd1;
    tick();
    idle(); bus.rt_d = 5'd9; bus.rt_used = 1'b1; bus.rt_tuse = 3'd1;
    #1 chk("alu_no_stall", 32'(bus.ifu_en), 32'd1);
    chk("alu_fwd_e_notready", 32'(bus.fwd_rt_sel), 32'd0);
    tick();
    chk("alu_fwd_m", 32'(bus.fwd_rt_sel), 32'd2);
    chk("alu_cnt", bus.stall_cnt, 32'd2);

    // $5 in both E (tnew 0) and M: youngest (E) wins.
    idle(); bus.a3_d = 5'd5; bus.tnew_d = 3'd1;
    tick();
    bus.tnew_d = 3'd0;
    tick();
    idle(); bus.rs_d = 5'd5; bus.rs_used = 1'b1;
    #1 chk("youngest_fwd_e", 32'(bus.fwd_rs_sel), 32'd1);
    chk("youngest_no_stall", 32'(bus.ifu_en), 32'd1);
    bus.rs_d = 5'd0;
    #1 chk("zero_addr_fwd", 32'(bus.fwd_rs_sel), 32'd0);
    chk("zero_addr_no_stall", 32'(bus.ifu_en), 32'd1);
    bus.rs_d = 5'd5; bus.rs_used = 1'b0;
    #1 chk("unused_fwd", 32'(bus.fwd_rs_sel), 32'd0);
    tick();

    // div then mflo: exactly DIV_CYC stall cycles.
    idle(); bus.md_start_d = 1'b1; bus.md_div_d = 1'b1; bus.md_use_d = 1'b1;
    #1 chk("div_accept", 32'(bus.ifu_en), 32'd1);
    tick();
    idle(); bus.md_use_d = 1'b1;
    #1 chk("div_busy", 32'(bus.md_busy), 32'd1);
    count_stall(n);
    chk("div_stall_cycles", 32'(n), 32'd10);
    chk("div_cnt", bus.stall_cnt, 32'd12);
    tick();

    // mult then mflo: MULT_CYC stall cycles.
    idle(); bus.md_start_d = 1'b1; bus.md_use_d = 1'b1;
    tick();
    idle(); bus.md_use_d = 1'b1;
    count_stall(n);
    chk("mult_stall_cycles", 32'(n), 32'd5);
    chk("mult_cnt", bus.stall_cnt, 32'd17);
    tick();

    // Reset while the divide counter reads 4 aborts the count.
    idle(); bus.md_start_d = 1'b1; bus.md_div_d = 1'b1; bus.md_use_d = 1'b1;
    tick();
    idle(); bus.md_use_d = 1'b1;
    repeat (6) tick();
    chk("abort_busy_before", 32'(bus.md_busy), 32'd1);
    reset = 1'b0;
    #1 chk("abort_busy", 32'(bus.md_busy), 32'd0);
    chk("abort_ifu_en", 32'(bus.ifu_en), 32'd1);
    chk("abort_cnt", bus.stall_cnt, 32'd0);
    #2 reset = 1'b1;
    #1 chk("post_rst_mflo", 32'(bus.ifu_en), 32'd1);
    tick();
    chk("post_rst_mflo_edge", 32'(bus.ifu_en), 32'd1);
    chk("post_rst_cnt", bus.stall_cnt, 32'd0);
    idle();

    // Narrow stall counter saturates at 15 under a 20-cycle divide stall.
    bus2.md_start_d = 1'b1; bus2.md_div_d = 1'b1; bus2.md_use_d = 1'b1;
    tick();
    idle2(); bus2.md_use_d = 1'b1;
    #1 chk("sat_stalling", 32'(bus2.ifu_en), 32'd0);
    repeat (15) tick();
    chk("sat_reach", 32'(bus2.stall_cnt), 32'd15);
    repeat (5) tick();
    chk("sat_hold", 32'(bus2.stall_cnt), 32'd15);
    chk("sat_busy_done", 32'(bus2.md_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
